mac_engine: RTL and testbench
=============================

Name: mac_engine

Overview:
- Sequential signed multiply-accumulate engine for short dot products / FIR taps: y = (sum over k=0..n-1 of a[k]*x[k]) >>> s.
- On a start pulse, it walks an index i_o from 0 to n-1, one term per clock.
- It reads operands from external combinational lookup tables (x table and coefficient table) addressed by i_o.
- When done, it presents a rescaled, saturated 18-bit result and pulses end-of-frame.

Parameters:
- XW, 18, width of x_i and y_o (signed, A(7,10) in the reference use).
- AW, 36, width of a_i (signed, A(7,28)).
- IW, 6, width of i_o, n_i, s_i.
- GW, 6, accumulator guard bits. Accumulator width = XW+AW+GW = 60.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- stf_i  in  1  start-of-frame pulse, sampled on clock edge.
- x_i  in  18  signed sample at address i_o, valid combinationally in the same cycle.
- a_i  in  36  signed coefficient at address i_o, valid combinationally in the same cycle.
- n_i  in  6  number of terms (0..63), sampled at start.
- s_i  in  6  arithmetic right-shift applied to the accumulator, sampled at start.
- y_o  out  18  signed result, registered, held until next result.
- i_o  out  6  current table address (registered).
- eof_o  out  1  one-cycle pulse: y_o updated this cycle.

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, acc=0, i_o=0, y_o=0, eof_o=0, latched n/s=0. Reset has priority over everything, including mid-run; no eof_o is produced for an aborted run.
- States: IDLE, RUN, DONE.
- IDLE:
  - stf_i=1 latches n_i and s_i, clears acc, sets i_o=0.
  - Goes to RUN, or to DONE directly if n_i=0.
- RUN, each cycle:
  - acc <= acc + sext(a_i*x_i). The product is a full 54-bit signed product, sign-extended to 60 bits.
  - If i_o == n-1, go to DONE; otherwise i_o <= i_o+1.
- DONE:
  - y_o <= sat18(acc >>> s), truncation toward minus infinity, no rounding.
  - Saturation bounds: +131071 / -131072.
  - eof_o=1 for exactly this cycle.
  - i_o <= 0, return to IDLE.
- Latency: stf_i sampled at edge T. Terms are accumulated at edges T+1..T+n. y_o/eof_o are valid after edge T+n+1. For n=5 that is 6 cycles after start.
- stf_i while in RUN or DONE is ignored (no restart, no queuing). A new stf_i is accepted in the cycle eof_o is high, since the state is back in IDLE then.
- i_o is stable for a full cycle per term, so the external tables have one cycle of combinational settle time.
- Fixed point: A(7,10)*A(7,28) gives an A(15,38) product. s=28 yields an A(7,10) result.
- The accumulator never overflows for n<=63 (6 guard bits). Only the final shift/narrow saturates.
- n_i/s_i changes during a run have no effect.

Decomposition:
- Shared package mac_pkg:
  - widths XW, AW, IW, GW, ACCW.
  - state enum {IDLE, RUN, DONE}.
  - SAT_MAX/SAT_MIN constants.
- One natural sub-module: mac_shift_sat, purely combinational. Takes the 60-bit acc and s, returns the 18-bit saturated result.
- Control FSM, index counter and accumulator stay in mac_engine.
- Bench-only table models (x table, coefficient table) are outside this block.

Test Plan:
- Basic sum: tables x[k]=1024 (1.0), a[k]=2^28 (1.0), n=5, s=28, stf pulse. Required: i_o steps 0..4, eof_o pulses 6 cycles after start, y_o=5120 (5.0).
- Signed mix: x={1024,-2048,512,0,3072}, a=2^28·{1,1,-2,5,-1}, n=5, s=28. Required: y_o = 1024-2048-1024+0-3072 = -5120.
- Saturation: x=131071, a=2^35-1, n=5, s=28. Required: y_o=131071. Negated a gives y_o=-131072.
- Edge cases for n and back-to-back runs:
  - n=0: eof_o 1 cycle after start, y_o=0.
  - Two back-to-back starts with a 2-cycle gap give identical y_o.
  - stf_i asserted mid-RUN is ignored (same timing and result).
- Reset mid-run: assert rst_i at term 2. Required: next cycle y_o=0, i_o=0, eof_o=0, state IDLE. A subsequent start gives the correct 5120.
- Shift: same data as the basic sum with s=30. Required: y_o=1280 (floor); with s=0, y_o saturates to 131071.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, state encoding and saturation limits for the MAC engine.
package mac_pkg;
  localparam int XW   = 18;
  localparam int AW   = 36;
  localparam int IW   = 6;
  localparam int GW   = 6;
  localparam int PW   = XW + AW;
  localparam int ACCW = XW + AW + GW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic signed [XW-1:0] SAT_MAX = {1'b0, {(XW-1){1'b1}}};
  localparam logic signed [XW-1:0] SAT_MIN = {1'b1, {(XW-1){1'b0}}};
endpackage

// File: rtl/mac_engine_if.sv
// Table-lookup and result bundle between the MAC engine and its environment.
interface mac_engine_if;
  import mac_pkg::*;

  logic                 stf_i;
  logic signed [XW-1:0] x_i;
  logic signed [AW-1:0] a_i;
  logic [IW-1:0]        n_i;
  logic [IW-1:0]        s_i;
  logic signed [XW-1:0] y_o;
  logic [IW-1:0]        i_o;
  logic                 eof_o;

  modport master (output stf_i, x_i, a_i, n_i, s_i, input y_o, i_o, eof_o);
  modport slave  (input stf_i, x_i, a_i, n_i, s_i, output y_o, i_o, eof_o);
endinterface

// File: rtl/mac_shift_sat.sv
// Arithmetic right shift of the accumulator, then clamp to the signed result width.
module mac_shift_sat
  import mac_pkg::*;
(
  input  logic signed [ACCW-1:0] acc_i,
  input  logic [IW-1:0]          s_i,
  output logic signed [XW-1:0]   y_o
);
  logic signed [ACCW-1:0] sh;

  always_comb begin
    sh = acc_i >>> s_i;
    // Fits when every bit above the result sign bit matches it.
    if (sh[ACCW-1:XW-1] == {(ACCW-XW+1){sh[ACCW-1]}}) begin
      y_o = sh[XW-1:0];
    end else begin
      y_o = sh[ACCW-1] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/mac_engine.sv
// Sequential signed multiply-accumulate: one table term per clock, then
// shift/saturate into an 18-bit result with an end-of-frame pulse.
module mac_engine
  import mac_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  mac_engine_if.slave  bus
);
  state_e                 state_q, state_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [IW-1:0]          i_q, i_d;
  logic [IW-1:0]          n_q, n_d;
  logic [IW-1:0]          s_q, s_d;
  logic signed [XW-1:0]   y_q, y_d;
  logic                   eof_q, eof_d;
  logic signed [PW-1:0]   prod;
  logic signed [XW-1:0]   y_sat;

  assign prod = bus.a_i * bus.x_i;

  mac_shift_sat u_shift_sat (
    .acc_i (acc_q),
    .s_i   (s_q),
    .y_o   (y_sat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      s_q     <= '0;
      y_q     <= '0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      n_q     <= n_d;
      s_q     <= s_d;
      y_q     <= y_d;
      eof_q   <= eof_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    i_d     = i_q;
    n_d     = n_q;
    s_d     = s_q;
    y_d     = y_q;
    eof_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.stf_i) begin
          n_d     = bus.n_i;
          s_d     = bus.s_i;
          acc_d   = '0;
          i_d     = '0;
          state_d = (bus.n_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + {{GW{prod[PW-1]}}, prod};
        // RUN is only entered with n >= 1, so n-1 never wraps here.
        if (i_q == n_q - IW'(1)) begin
          state_d = DONE;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      DONE: begin
        y_d     = y_sat;
        eof_d   = 1'b1;
        i_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.y_o   = y_q;
  assign bus.i_o   = i_q;
  assign bus.eof_o = eof_q;
endmodule

// File: tb/tb_mac_engine.sv
// Scoreboard bench for mac_engine: behavioural dot-product model, directed and random frames.
module tb_mac_engine;
  logic clk = 1'b0;
  logic rst;
  mac_engine_if bus ();

  mac_engine dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  logic signed [17:0] xt [64];
  logic signed [35:0] at [64];
  assign bus.x_i = xt[bus.i_o];
  assign bus.a_i = at[bus.i_o];

  typedef struct {
    logic signed [17:0] y;
    int                 cyc;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [17:0] ref_y(input int n, input int s);
    longint acc = 0;
    longint sh;
    for (int k = 0; k < n; k++) acc += longint'(xt[k]) * longint'(at[k]);
    sh = acc >>> s;
    if (sh > 131071) return 18'sd131071;
    if (sh < -131072) return -18'sd131072;
    return 18'(sh);
  endfunction

  // Monitor: compares every presented result against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (bus.eof_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_eof", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("y_o", bus.y_o, e.y);
        chk("eof_cycle", cyc, e.cyc);
      end
    end
  end

  // Drives a one-cycle start; 'now' means the caller is already at a negedge.
  task automatic start(input int n, input int s, input bit now = 0);
    exp_t e;
    if (!now) @(negedge clk);
    bus.stf_i = 1'b1;
    bus.n_i   = 6'(n);
    bus.s_i   = 6'(s);
    e.y   = ref_y(n, s);
    e.cyc = cyc + 1 + n + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.stf_i = 1'b0;
  endtask

  task automatic wait_done();
    int c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic fill(input logic signed [17:0] x, input logic signed [35:0] a);
    for (int k = 0; k < 64; k++) begin
      xt[k] = x;
      at[k] = a;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.stf_i = 1'b0;
    bus.n_i = '0;
    bus.s_i = '0;
    fill(18'sd0, 36'sd0);
    repeat (3) @(negedge clk);
    chk("rst_y", bus.y_o, 0);
    chk("rst_i", bus.i_o, 0);
    chk("rst_eof", bus.eof_o, 0);
    rst = 1'b0;

    // Basic sum with index walk.
    fill(18'sd1024, 36'sd268435456);
    start(5, 28);
    chk("idx0", bus.i_o, 0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk("idx_step", bus.i_o, k);
    end
    wait_done();
    chk("basic_5120", bus.y_o, 5120);

    // Signed mix.
    xt[0] = 18'sd1024;  at[0] = 36'sd268435456;
    xt[1] = -18'sd2048; at[1] = 36'sd268435456;
    xt[2] = 18'sd512;   at[2] = -36'sd536870912;
    xt[3] = 18'sd0;     at[3] = 36'sd1342177280;
    xt[4] = 18'sd3072;  at[4] = -36'sd268435456;
    start(5, 28);
    wait_done();
    chk("mix_m5120", bus.y_o, -5120);

    // Saturation both ways.
    fill(18'sd131071, 36'sh7_FFFF_FFFF);
    start(5, 28);
    wait_done();
    fill(18'sd131071, -36'sh7_FFFF_FFFF);
    start(5, 28);
    wait_done();

    // Shift amounts.
    fill(18'sd1024, 36'sd268435456);
    start(5, 30);
    wait_done();
    chk("shift30", bus.y_o, 1280);
    start(5, 0);
    wait_done();

    // n = 0, then back-to-back with a gap, then start in the eof cycle.
    start(0, 28);
    wait_done();
    start(5, 28);
    wait_done();
    repeat (2) @(negedge clk);
    start(5, 28);
    wait_done();
    start(3, 28, 1);
    wait_done();

    // Start pulse mid-run with different n/s is ignored.
    start(5, 28);
    @(negedge clk);
    bus.stf_i = 1'b1;
    bus.n_i = 6'd2;
    bus.s_i = 6'd0;
    @(negedge clk);
    bus.stf_i = 1'b0;
    wait_done();

    // Reset mid-run at term 2, then a clean run.
    start(5, 30);
    for (int c = 0; c < 20 && bus.i_o != 2; c++) @(negedge clk);
    chk("reach_term2", bus.i_o, 2);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_y", bus.y_o, 0);
    chk("midrst_i", bus.i_o, 0);
    chk("midrst_eof", bus.eof_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    start(5, 28);
    wait_done();
    chk("post_rst_5120", bus.y_o, 5120);

    // Random frames, some started in the eof cycle.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 64; k++) begin
        xt[k] = 18'($urandom);
        at[k] = 36'({$urandom, $urandom});
      end
      start($urandom_range(0, 63), $urandom_range(0, 63), (r % 3) == 0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
